// File: rtl/stage_sequencer.sv
// Multi-cycle IF/ID/EX/MEM/WB stage sequencer driving main_control's 3-bit stage code.
// Registered stage output; retire/illegal_op are Mealy pulses decoded from the current stage.
module stage_sequencer #(
  parameter int CNT_W       = 16,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic [5:0]       i_op,
  input  logic             i_mem_ready,
  input  logic             i_halt_req,
  output logic [2:0]       o_stage,
  output logic             o_retire,
  output logic             o_illegal_op,
  output logic             o_mem_timeout,
  output logic             o_halted,
  output logic [CNT_W-1:0] o_instr_count
);

  typedef enum logic [2:0] {
    S_IDLE = 3'b000,
    S_IF   = 3'b001,
    S_ID   = 3'b010,
    S_EX   = 3'b011,
    S_MEM  = 3'b100,
    S_WB   = 3'b101
  } state_t;

  typedef enum logic [1:0] {
    C_ALU,
    C_LOAD,
    C_STORE,
    C_BRANCH
  } class_t;

  localparam logic [7:0] LP_WAIT_LAST = 8'(MEM_TIMEOUT - 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [5:0]       r_op_q;
  logic [7:0]       r_wait;
  logic [7:0]       w_wait_nxt;
  logic             r_mem_timeout;
  logic             r_halted;
  logic [CNT_W-1:0] r_instr_count;
  logic             w_retire;
  logic             w_illegal;
  logic             w_abort;
  logic             w_boundary;
  logic             w_latch_op;
  class_t           w_class;

  function automatic logic f_legal(input logic [5:0] op);
    // 001100 is the only hole in the 000000..010000 range
    return (op <= 6'd11) || ((op >= 6'd13) && (op <= 6'd16));
  endfunction

  function automatic class_t f_class(input logic [5:0] op);
    if (op <= 6'd4)                                    return C_ALU;
    else if (op == 6'd5 || op == 6'd6 || op == 6'd16)  return C_LOAD;
    else if (op == 6'd7 || (op >= 6'd13 && op <= 6'd15)) return C_STORE;
    else                                               return C_BRANCH;
  endfunction

  assign w_class = f_class(r_op_q);

  always_comb begin
    w_state_nxt = r_state;
    w_wait_nxt  = 8'd0;
    w_retire    = 1'b0;
    w_illegal   = 1'b0;
    w_abort     = 1'b0;
    w_boundary  = 1'b0;
    w_latch_op  = 1'b0;
    case (r_state)
      S_IDLE: w_boundary = 1'b1;
      S_IF:   w_state_nxt = S_ID;
      S_ID: begin
        if (f_legal(i_op)) begin
          w_state_nxt = S_EX;
          w_latch_op  = 1'b1;
        end else begin
          w_illegal  = 1'b1;
          w_boundary = 1'b1;
        end
      end
      S_EX: begin
        case (w_class)
          C_ALU:   w_state_nxt = S_WB;
          C_LOAD:  w_state_nxt = S_MEM;
          C_STORE: w_state_nxt = S_MEM;
          default: begin
            w_retire   = 1'b1;
            w_boundary = 1'b1;
          end
        endcase
      end
      S_MEM: begin
        // mem_ready takes priority over an expiring wait budget
        if (i_mem_ready) begin
          if (w_class == C_LOAD) begin
            w_state_nxt = S_WB;
          end else begin
            w_retire   = 1'b1;
            w_boundary = 1'b1;
          end
        end else if (r_wait == LP_WAIT_LAST) begin
          w_abort    = 1'b1;
          w_boundary = 1'b1;
        end else begin
          w_wait_nxt = r_wait + 8'd1;
        end
      end
      S_WB: begin
        w_retire   = 1'b1;
        w_boundary = 1'b1;
      end
      default: w_state_nxt = S_IDLE;
    endcase
    if (w_boundary) begin
      w_state_nxt = i_halt_req ? S_IDLE : S_IF;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state       <= S_IDLE;
      r_op_q        <= 6'd0;
      r_wait        <= 8'd0;
      r_mem_timeout <= 1'b0;
      r_halted      <= 1'b0;
      r_instr_count <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_wait   <= w_wait_nxt;
      r_halted <= w_boundary && i_halt_req;
      if (w_latch_op) begin
        r_op_q <= i_op;
      end
      if (w_abort) begin
        r_mem_timeout <= 1'b1;
      end
      if (w_retire) begin
        r_instr_count <= r_instr_count + CNT_W'(1);
      end
    end
  end

  assign o_stage       = r_state;
  assign o_retire      = w_retire;
  assign o_illegal_op  = w_illegal;
  assign o_mem_timeout = r_mem_timeout;
  assign o_halted      = r_halted;
  assign o_instr_count = r_instr_count;

endmodule
